// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scanner
// Brief    : N-digit multiplexed seven-segment driver with prescaler, PWM
//            brightness, blink/blank/dp control and frame-coherent capture.
// Revision : 1.0  initial release
// ============================================================================
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7*NUM_DIGITS-1:0] seg_data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              sseg,
  output logic                    dp_out,
  output logic                    frame_start
);

  localparam int c_SLOT_W = $clog2(SCAN_DIV);
  localparam int c_DIG_W  = $clog2(NUM_DIGITS);
  localparam int c_FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [c_SLOT_W-1:0] c_SLOT_MAX = c_SLOT_W'(SCAN_DIV - 1);
  localparam logic [c_SLOT_W-1:0] c_SLOT_ONE = c_SLOT_W'(1);
  localparam logic [c_DIG_W-1:0]  c_DIG_MAX  = c_DIG_W'(NUM_DIGITS - 1);
  localparam logic [c_DIG_W-1:0]  c_DIG_ONE  = c_DIG_W'(1);
  localparam logic [c_FRM_W-1:0]  c_FRM_MAX  = c_FRM_W'(BLINK_FRAMES - 1);
  localparam logic [c_FRM_W-1:0]  c_FRM_ONE  = c_FRM_W'(1);

  // Scan counters
  logic [c_SLOT_W-1:0] r_slot_cnt;
  logic [c_DIG_W-1:0]  r_digit;
  logic [c_FRM_W-1:0]  r_frame_cnt;
  logic                r_blink_phase;

  // Shadow copies of the display inputs, refreshed once per frame
  logic [7*NUM_DIGITS-1:0] r_seg_s;
  logic [NUM_DIGITS-1:0]   r_dp_s;
  logic [NUM_DIGITS-1:0]   r_blank_s;
  logic [NUM_DIGITS-1:0]   r_blink_s;
  logic [3:0]              r_bright_s;

  logic                  w_slot_wrap;
  logic                  w_frame_end;
  logic [3:0]            w_pwm;
  logic [6:0]            w_seg_cur;
  logic                  w_dp_cur;
  logic                  w_blank_cur;
  logic                  w_blink_cur;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_digit_sel;
  logic [NUM_DIGITS-1:0] w_an_raw;
  logic [6:0]            w_sseg_raw;
  logic                  w_dp_raw;

  assign w_slot_wrap = (r_slot_cnt == c_SLOT_MAX);
  assign w_frame_end = w_slot_wrap && (r_digit == '0);
  assign w_pwm       = r_slot_cnt[3:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_cnt    <= '0;
      r_digit       <= c_DIG_MAX;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      if (w_slot_wrap) begin
        r_slot_cnt <= '0;
        r_digit    <= (r_digit == '0) ? c_DIG_MAX : (r_digit - c_DIG_ONE);
      end else begin
        r_slot_cnt <= r_slot_cnt + c_SLOT_ONE;
      end

      if (w_frame_end) begin
        if (r_frame_cnt == c_FRM_MAX) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + c_FRM_ONE;
        end
      end
    end
  end

  // Loading throughout reset means the first frame after release is valid
  always_ff @(posedge clk) begin
    if (reset || w_frame_end) begin
      r_seg_s    <= seg_data;
      r_dp_s     <= dp;
      r_blank_s  <= blank;
      r_blink_s  <= blink;
      r_bright_s <= brightness;
    end
  end

  always_comb begin
    w_seg_cur   = '0;
    w_dp_cur    = 1'b0;
    w_blank_cur = 1'b0;
    w_blink_cur = 1'b0;
    w_digit_sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_digit == c_DIG_W'(i)) begin
        w_seg_cur      = r_seg_s[7*i +: 7];
        w_dp_cur       = r_dp_s[i];
        w_blank_cur    = r_blank_s[i];
        w_blink_cur    = r_blink_s[i];
        w_digit_sel[i] = 1'b1;
      end
    end
  end

  assign w_lit = ~reset & ~w_blank_cur & (~w_blink_cur | ~r_blink_phase)
               & (w_pwm <= r_bright_s);

  assign w_an_raw   = w_lit ? w_digit_sel : '0;
  assign w_sseg_raw = w_lit ? w_seg_cur : 7'h00;
  assign w_dp_raw   = w_lit & w_dp_cur;

  generate
    if (ACTIVE_LOW) begin : g_active_low
      assign an     = ~w_an_raw;
      assign sseg   = ~w_sseg_raw;
      assign dp_out = ~w_dp_raw;
    end else begin : g_active_high
      assign an     = w_an_raw;
      assign sseg   = w_sseg_raw;
      assign dp_out = w_dp_raw;
    end
  endgenerate

  assign frame_start = ~reset & (r_slot_cnt == '0) & (r_digit == c_DIG_MAX);

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scanner
// Brief    : Self-checking bench for a 4-digit and an 8-digit scanner.
// Revision : 1.0  initial release
// ============================================================================
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [55:0] seg56 = '0;
  logic [7:0]  dp8 = '0;
  logic [7:0]  blank8 = '0;
  logic [7:0]  blink8 = '0;
  logic [3:0]  bright = 4'd15;

  logic [3:0] an4;
  logic [6:0] sseg4;
  logic       dp4, fs4;
  logic [7:0] an8;
  logic [6:0] sseg8;
  logic       dp8o, fs8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(4), .SCAN_DIV(16), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)) u_dut4 (
    .clk(clk), .reset(reset), .seg_data(seg56[27:0]), .dp(dp8[3:0]), .blank(blank8[3:0]),
    .blink(blink8[3:0]), .brightness(bright), .an(an4), .sseg(sseg4), .dp_out(dp4),
    .frame_start(fs4));

  seven_seg_scanner #(.NUM_DIGITS(8), .SCAN_DIV(16), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)) u_dut8 (
    .clk(clk), .reset(reset), .seg_data(seg56), .dp(dp8), .blank(blank8),
    .blink(blink8), .brightness(bright), .an(an8), .sseg(sseg8), .dp_out(dp8o),
    .frame_start(fs8));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: position in the scan follows from cycles elapsed since release
  function automatic void model(input int n, input int t, input logic [55:0] seg,
                                input logic [7:0] dps, input logic [7:0] bl, input logic [7:0] bk,
                                input logic [3:0] br, output logic [7:0] e_an,
                                output logic [6:0] e_ss, output logic e_dp, output logic e_fs);
    int  d, frame;
    logic ph, lit;
    d     = n - 1 - ((t / 16) % n);
    frame = t / (16 * n);
    ph    = ((frame / 2) % 2) == 1;
    lit   = !bl[d] && (!bk[d] || !ph) && ((t % 16) <= int'(br));
    e_an  = 8'hFF;
    e_ss  = 7'h7F;
    e_dp  = 1'b1;
    if (lit) begin
      e_an[d] = 1'b0;
      e_ss    = ~seg[7*d +: 7];
      e_dp    = ~dps[d];
    end
    e_fs = (t % (16 * n)) == 0;
  endfunction

  int          m_t = 0;
  bit          m_valid = 0;
  logic [55:0] s4_seg, s8_seg;
  logic [7:0]  s4_dp, s4_bl, s4_bk, s8_dp, s8_bl, s8_bk;
  logic [3:0]  s4_br, s8_br;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1;
      m_t     = 0;
      s4_seg = seg56; s4_dp = dp8; s4_bl = blank8; s4_bk = blink8; s4_br = bright;
      s8_seg = seg56; s8_dp = dp8; s8_bl = blank8; s8_bk = blink8; s8_br = bright;
    end else if (m_valid) begin
      if (m_t % 64 == 63) begin
        s4_seg = seg56; s4_dp = dp8; s4_bl = blank8; s4_bk = blink8; s4_br = bright;
      end
      if (m_t % 128 == 127) begin
        s8_seg = seg56; s8_dp = dp8; s8_bl = blank8; s8_bk = blink8; s8_br = bright;
      end
      m_t++;
    end
  end

  logic [7:0] e_an;
  logic [6:0] e_ss;
  logic       e_dp, e_fs;

  always @(negedge clk) begin
    if (m_valid) begin
      if (reset) begin
        check("an4_rst", {60'd0, an4}, 64'hF);
        check("sseg4_rst", {57'd0, sseg4}, 64'h7F);
        check("dp4_rst", {63'd0, dp4}, 64'h1);
        check("fs4_rst", {63'd0, fs4}, 64'h0);
        check("an8_rst", {56'd0, an8}, 64'hFF);
        check("fs8_rst", {63'd0, fs8}, 64'h0);
      end else begin
        model(4, m_t, s4_seg, s4_dp, s4_bl, s4_bk, s4_br, e_an, e_ss, e_dp, e_fs);
        check("an4", {60'd0, an4}, {60'd0, e_an[3:0]});
        check("sseg4", {57'd0, sseg4}, {57'd0, e_ss});
        check("dp4", {63'd0, dp4}, {63'd0, e_dp});
        check("fs4", {63'd0, fs4}, {63'd0, e_fs});
        model(8, m_t, s8_seg, s8_dp, s8_bl, s8_bk, s8_br, e_an, e_ss, e_dp, e_fs);
        check("an8", {56'd0, an8}, {56'd0, e_an});
        check("sseg8", {57'd0, sseg8}, {57'd0, e_ss});
        check("dp8", {63'd0, dp8o}, {63'd0, e_dp});
        check("fs8", {63'd0, fs8}, {63'd0, e_fs});
      end
    end
  end

  // Called just after a posedge; leaves the bench in cycle 0 after release
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Scan order, frame coherence, 8-digit sweep
    seg56  = {7'h10, 7'h20, 7'h40, 7'h03, 7'h01, 7'h02, 7'h04, 7'h08};
    dp8    = 8'h00; blank8 = 8'h00; blink8 = 8'h00; bright = 4'd15;
    do_reset();
    for (int c = 0; c < 140; c++) begin
      if (c == 20) seg56[27:21] = 7'h7F;
      @(negedge clk);
      case (c)
        0: begin
          check("lit_an4_c0", {60'd0, an4}, 64'h7);
          check("lit_sseg4_c0", {57'd0, sseg4}, 64'h7E);
          check("lit_fs4_c0", {63'd0, fs4}, 64'h1);
          check("lit_an8_c0", {56'd0, an8}, 64'h7F);
        end
        10: check("lit_sseg4_c10", {57'd0, sseg4}, 64'h7E);
        16: begin
          check("lit_an4_c16", {60'd0, an4}, 64'hB);
          check("lit_sseg4_c16", {57'd0, sseg4}, 64'h7D);
        end
        32: check("lit_sseg4_c32", {57'd0, sseg4}, 64'h7B);
        48: begin
          check("lit_an4_c48", {60'd0, an4}, 64'hE);
          check("lit_sseg4_c48", {57'd0, sseg4}, 64'h77);
        end
        64: begin
          check("lit_fs4_c64", {63'd0, fs4}, 64'h1);
          check("lit_sseg4_c64", {57'd0, sseg4}, 64'h00);
          check("lit_fs8_c64", {63'd0, fs8}, 64'h0);
        end
        112: check("lit_an8_c112", {56'd0, an8}, 64'hFE);
        128: begin
          check("lit_fs4_c128", {63'd0, fs4}, 64'h1);
          check("lit_fs8_c128", {63'd0, fs8}, 64'h1);
        end
        default: ;
      endcase
      next_cycle();
    end

    // Mid-frame reset pulse
    seg56 = {7'h10, 7'h20, 7'h40, 7'h03, 7'h01, 7'h02, 7'h04, 7'h08};
    do_reset();
    for (int c = 0; c < 60; c++) begin
      if (c == 40) reset = 1'b1;
      if (c == 41) reset = 1'b0;
      @(negedge clk);
      if (c == 40) begin
        check("lit_an4_rst40", {60'd0, an4}, 64'hF);
        check("lit_sseg4_rst40", {57'd0, sseg4}, 64'h7F);
      end
      if (c == 41) begin
        check("lit_an4_c41", {60'd0, an4}, 64'h7);
        check("lit_fs4_c41", {63'd0, fs4}, 64'h1);
      end
      next_cycle();
    end

    // Blank and blink
    blank8 = 8'b0000_0010; blink8 = 8'b0000_0001;
    do_reset();
    for (int c = 0; c < 320; c++) begin
      @(negedge clk);
      case (c)
        32:  check("lit_an4_blank", {60'd0, an4}, 64'hF);
        48:  check("lit_an4_f0_d0", {60'd0, an4}, 64'hE);
        112: check("lit_an4_f1_d0", {60'd0, an4}, 64'hE);
        176: check("lit_an4_f2_d0", {60'd0, an4}, 64'hF);
        240: check("lit_an4_f3_d0", {60'd0, an4}, 64'hF);
        304: check("lit_an4_f4_d0", {60'd0, an4}, 64'hE);
        default: ;
      endcase
      next_cycle();
    end

    // Brightness
    blank8 = 8'h00; blink8 = 8'h00; bright = 4'd3;
    do_reset();
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      case (c)
        3:  check("lit_an4_br3", {60'd0, an4}, 64'h7);
        4:  check("lit_an4_br4", {60'd0, an4}, 64'hF);
        15: check("lit_an4_br15", {60'd0, an4}, 64'hF);
        19: check("lit_an4_br19", {60'd0, an4}, 64'hB);
        20: check("lit_an4_br20", {60'd0, an4}, 64'hF);
        default: ;
      endcase
      next_cycle();
    end

    // Randomized inputs with occasional reset pulses
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      seg56  = {$urandom, $urandom};
      dp8    = 8'($urandom);
      blank8 = 8'($urandom & $urandom & $urandom);
      blink8 = 8'($urandom & $urandom);
      bright = 4'($urandom);
      reset  = ($urandom_range(0, 199) == 0);
      next_cycle();
    end
    reset = 1'b0;
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised multiplexed seven-segment display driver for the Fitbit display path. It is the next generation of the fixed 4-digit scanner and supports N digits, a built-in refresh prescaler, and per-digit blank, blink and decimal-point control. It adds global PWM brightness and frame-coherent input capture, so a multi-digit value never tears mid-scan. It sits between the stopwatch/step-count formatting logic and the board's anode/cathode pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (2..8)
- SCAN_DIV, 100000, clk cycles per digit slot (≥16, multiple of 16)
- BLINK_FRAMES, 64, frames per blink half-period (≥1)
- ACTIVE_LOW, 1, 1: an/sseg/dp_out active-low (off = all ones); 0: active-high
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- seg_data  in  7*NUM_DIGITS  digit i at [7i+6:7i]; bit set = segment lit; digit NUM_DIGITS-1 is leftmost
- dp  in  NUM_DIGITS  per-digit decimal point, 1 = lit
- blank  in  NUM_DIGITS  1 = digit dark
- blink  in  NUM_DIGITS  1 = digit blinks
- brightness  in  4  duty: digit lit (brightness+1)/16 of its slot
- an  out  NUM_DIGITS  digit enables, one-hot when lit
- sseg  out  7  segment pattern of current digit
- dp_out  out  1  decimal point of current digit
- frame_start  out  1  one-cycle pulse on first cycle of each frame

## Operation
- Counters, all cleared by reset:
  - slot_cnt: 0..SCAN_DIV-1.
  - pwm_cnt: 4-bit, equal to slot_cnt[3:0].
  - d: current digit, reset to NUM_DIGITS-1.
  - frame_cnt: 0..BLINK_FRAMES-1.
  - blink_phase: reset 0 (visible).
- slot_cnt increments every cycle. When it wraps, d decrements. At d=0 it wraps to NUM_DIGITS-1, giving scan order left to right.
- Frame end is the edge where slot_cnt=SCAN_DIV-1 and d=0. At that edge:
  - frame_cnt increments.
  - When frame_cnt wraps, blink_phase toggles.
- Shadow registers hold seg_data, dp, blank, blink and brightness. They load the live inputs:
  - at every frame-end edge, and
  - on every cycle while reset is high.
- Input changes mid-frame are ignored until the next frame.
- Digit d is lit iff all of the following hold:
  - reset=0,
  - blank_s[d]=0,
  - blink_s[d]=0 or blink_phase=0,
  - pwm_cnt ≤ bright_s.
- When digit d is lit:
  - an bit d is active and all other an bits are off.
  - sseg = seg_s[d].
  - dp_out = dp_s[d].
- When digit d is not lit, an, sseg and dp_out are all off.
- With ACTIVE_LOW=1, an, sseg and dp_out are inverted at the output.
- frame_start = (slot_cnt=0 && d=NUM_DIGITS-1 && reset=0).
- Outputs are combinational from registers only. Live inputs never reach the outputs directly.

## Timing
- Reset values: an, sseg and dp_out are off (all ones when ACTIVE_LOW=1), and frame_start=0, for every cycle reset is high.
- First cycle after reset deasserts:
  - frame_start=1.
  - Digit NUM_DIGITS-1 is shown from the shadow loaded during reset. There is no blank first frame.
- Slot = SCAN_DIV cycles. Frame = NUM_DIGITS·SCAN_DIV cycles. Blink period = 2·BLINK_FRAMES frames.
- Input-to-display latency: visible from the first cycle of the next frame.
- Within each slot, the digit is lit on cycles where slot_cnt[3:0] ≤ brightness.
  - brightness=15: lit the entire slot.
  - brightness=0: lit 1 cycle in 16.
- Reset asserted mid-frame:
  - Outputs go off on that cycle.
  - All counters and blink_phase return to reset values at the next edge.
  - Scanning restarts from the leftmost digit after release.
- Simultaneous frame end and input change: the value present at the frame-end edge is captured.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=16, BLINK_FRAMES=2, ACTIVE_LOW=1 and brightness=15 unless stated.
- **Scan order.** Stimulus: reset 3 cycles, then seg_data={7'h01,7'h02,7'h04,7'h08}. Required response:
  - an = 0111, 1011, 1101, 1110, 16 cycles each, repeating.
  - sseg = 7'h7E, 7'h7D, 7'h7B, 7'h77 respectively.
  - frame_start high on cycles 0, 64, 128 after release.
- **Frame coherence.** Stimulus: change seg_data[27:21] to 7'h7F at cycle 20. Required response:
  - sseg for digit 3 stays 7'h7E through cycles 0–15.
  - Digit 3 shows 7'h00 starting at cycle 64.
  - Digit 3 does not change at cycle 20.
- **Blank and blink.** Stimulus: blank=4'b0010, blink=4'b0001. Required response:
  - an never 4'b1101.
  - Digit 0 lit in frames 0–1, dark in frames 2–3, lit again in frame 4.
- **Brightness.** Stimulus: brightness=3. Required response:
  - In each slot, the an bit is active only on the first 4 cycles.
  - an = 4'b1111 on the remaining 12 cycles.
- **Mid-frame reset.** Stimulus: reset pulsed for 1 cycle at cycle 40 (digit 1 slot). Required response:
  - Outputs are all ones on cycle 40.
  - On cycle 41, an=0111 and frame_start=1.
- **Parameter sweep.** Stimulus: NUM_DIGITS=8, same stimulus pattern. Required response:
  - an walks 01111111 → 11111110, 16 cycles per step.
  - frame_start every 128 cycles.
